fp16_accum_seq: RTL

Sequencer that drives the fp16 adder wrapper (its op_a/op_b/mode/res_o interface) as an initiator to reduce a stream of fp16 values into one signed sum. A length is programmed with a start pulse, elements arrive on a valid/ready stream, and each element is issued to the adder as acc ± x. The adder result is captured back into the accumulator after the adder's fixed latency. The final sum is presented on a valid/ready output. It sits in the SFU between the operand buffer and the adder, where row sums and normalisation sums are needed.

---
 rtl/fp16_accum_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: reduces a programmed-length stream of fp16 values into one
// signed sum by driving an external pipelined fp16 adder as acc +/- x and
// capturing its result after a fixed latency. No fp arithmetic happens here.
module fp16_accum_seq #(
  parameter int ADD_LAT = 2,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_data_i,
  input  logic             in_sub_i,
  output logic [15:0]      add_op_a_o,
  output logic [15:0]      add_op_b_o,
  output logic             add_mode_o,
  input  logic [15:0]      add_res_i,
  output logic             busy_o,
  output logic             out_valid_o,
  output logic [15:0]      out_data_o,
  input  logic             out_ready_i
);

  localparam int WCNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         acc_q;
  logic [LEN_W-1:0]    rem_q;
  logic [WCNT_W-1:0]   wcnt_q;

  logic start_fire;
  logic in_fire;
  logic capture;
  logic last_elem;

  assign start_fire = (state_q == S_IDLE) && start_i;
  assign in_fire    = (state_q == S_ACCEPT) && in_valid_i;
  assign capture    = (state_q == S_WAIT) && (wcnt_q == '0);
  assign last_elem  = (rem_q == LEN_W'(1));

  assign in_ready_o  = (state_q == S_ACCEPT);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  // acc only changes on a capture in WAIT, so it is stable throughout DONE.
  assign out_data_o  = acc_q;

  // Next-state logic for the IDLE -> ACCEPT <-> WAIT -> DONE sequence.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i)     state_d = (len_i == '0) ? S_DONE : S_ACCEPT;
      S_ACCEPT: if (in_valid_i)  state_d = S_WAIT;
      S_WAIT:   if (capture)     state_d = last_elem ? S_DONE : S_ACCEPT;
      S_DONE:   if (out_ready_i) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Accumulator, element counter, latency counter and registered adder operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      rem_q      <= '0;
      wcnt_q     <= '0;
      add_op_a_o <= '0;
      add_op_b_o <= '0;
      add_mode_o <= 1'b0;
    end else begin
      if (start_fire) begin
        acc_q <= 16'h0000;
        rem_q <= len_i;
      end
      // Operands are held outside the handshake: the adder samples every cycle.
      if (in_fire) begin
        add_op_a_o <= acc_q;
        add_op_b_o <= in_data_i;
        add_mode_o <= in_sub_i;
        wcnt_q     <= WCNT_W'(ADD_LAT);
      end
      if (state_q == S_WAIT) begin
        if (capture) begin
          acc_q <= add_res_i;
          rem_q <= rem_q - LEN_W'(1);
        end else begin
          wcnt_q <= wcnt_q - WCNT_W'(1);
        end
      end
    end
  end

endmodule
